// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data access ports.
// Data has priority, but back-to-back contention alternates so fetch cannot starve.
//
//  state | meaning
//  IDLE  | no access in flight; arbitrate pending requests
//  IACC  | instruction read holding the RAM port, counting wait cycles
//  DACC  | data read or write holding the RAM port, counting wait cycles
module memory_arbiter #(
   parameter int LAT = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          iREN,
   input  logic [AW-1:0] iaddr,
   output logic          ihit,
   output logic [DW-1:0] iload,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic [AW-1:0] daddr,
   input  logic [DW-1:0] dstore,
   output logic          dhit,
   output logic [DW-1:0] dload,
   output logic          ramREN,
   output logic          ramWEN,
   output logic [AW-1:0] ramaddr,
   output logic [DW-1:0] ramstore,
   input  logic [DW-1:0] ramload
);

   typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t        state, state_nx;
   logic [3:0]    cnt;
   logic          last_d;
   logic          op_wr;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] store_q;
   logic [DW-1:0] iload_q;
   logic [DW-1:0] dload_q;
   logic          dreq;
   logic          done;

   assign dreq = dREN | dWEN;
   assign done = (cnt == LAT_C);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (dreq && iREN && last_d) state_nx = IACC;
            else if (dreq)              state_nx = DACC;
            else if (iREN)              state_nx = IACC;
         end
         IACC:    if (!iREN || done) state_nx = IDLE;
         DACC:    if (!dreq || done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Hits are gated by RST so a reset landing on the completion cycle aborts cleanly.
   always_comb begin
      ihit   = (state == IACC) && iREN && done && !RST;
      dhit   = (state == DACC) && dreq && done && !RST;
      ramREN = (state == IACC) || ((state == DACC) && !op_wr);
      ramWEN = (state == DACC) && op_wr;
      iload  = ihit ? ramload : iload_q;
      dload  = dhit ? ramload : dload_q;
   end

   assign ramaddr  = addr_q;
   assign ramstore = store_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= 4'd0;
         last_d  <= 1'b0;
         op_wr   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         if (state == IDLE) begin
            cnt <= 4'd0;
            if (state_nx == IACC) begin
               addr_q <= iaddr;
            end else if (state_nx == DACC) begin
               addr_q  <= daddr;
               store_q <= dstore;
               op_wr   <= dWEN;
            end
         end else if (state_nx == IDLE) begin
            cnt <= 4'd0;
         end else if (!done) begin
            cnt <= cnt + 4'd1;
         end
         if (ihit) begin
            iload_q <= ramload;
            last_d  <= 1'b0;
         end
         if (dhit) begin
            dload_q <= ramload;
            last_d  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at LAT=2, one at LAT=0, shared inputs.
module tb_memory_arbiter;

   logic        CLK, RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;

   logic        ihit, dhit, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        ihit0, dhit0, ramREN0, ramWEN0;
   logic [31:0] iload0, dload0, ramaddr0, ramstore0;

   int n_vec = 0;
   int n_err = 0;

   memory_arbiter #(.LAT(2), .AW(32), .DW(32)) u_dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload)
   );

   memory_arbiter #(.LAT(0), .AW(32), .DW(32)) u_lat0 (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit0), .iload(iload0),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit0), .dload(dload0),
      .ramREN(ramREN0), .ramWEN(ramWEN0), .ramaddr(ramaddr0), .ramstore(ramstore0),
      .ramload(ramload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Leaves the bench at the start of cycle 0 with the DUT idle.
   task automatic do_reset();
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h5A5A_5A5A;
      cyc();
      cyc();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

      // reset values
      cyc();
      cyc();
      #2;
      check_val("rst_ihit",     ihit,      0);
      check_val("rst_dhit",     dhit,      0);
      check_val("rst_iload",    iload,     0);
      check_val("rst_dload",    dload,     0);
      check_val("rst_ramren",   ramREN,    0);
      check_val("rst_ramwen",   ramWEN,    0);
      check_val("rst_ramaddr",  ramaddr,   0);
      check_val("rst_ramstore", ramstore,  0);
      check_val("rst0_dload",   dload0,    0);
      check_val("rst0_ramstore",ramstore0, 0);

      // single instruction fetch
      do_reset();
      iREN = 1'b1; iaddr = 32'h40; ramload = 32'hDEAD_0001;
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) begin
            iREN = 1'b0; ramload = 32'h0BAD_BEEF;
         end
         #2;
         check_val("if_ramren", ramREN, (c >= 1 && c <= 3));
         check_val("if_ihit",   ihit,   (c == 3));
         check_val("if_dhit",   dhit,   0);
         if (c >= 1) check_val("if_ramaddr", ramaddr, 32'h40);
         if (c >= 3) check_val("if_iload",   iload,   32'hDEAD_0001);
         cyc();
      end

      // data write, address/data changed mid-access must be ignored
      dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234_5678;
      for (int c = 0; c <= 4; c++) begin
         if (c == 2) begin
            daddr = 32'hFFF0; dstore = 32'h9999_9999;
         end
         if (c == 4) dWEN = 1'b0;
         #2;
         check_val("dw_ramwen", ramWEN, (c >= 1 && c <= 3));
         check_val("dw_ramren", ramREN, 0);
         check_val("dw_dhit",   dhit,   (c == 3));
         check_val("dw_ihit",   ihit,   0);
         if (c >= 1) begin
            check_val("dw_ramaddr",  ramaddr,  32'h80);
            check_val("dw_ramstore", ramstore, 32'h1234_5678);
         end
         cyc();
      end

      // both ports held: D, I, D, I with hits at 3, 7, 11, 15
      do_reset();
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
      for (int c = 0; c <= 16; c++) begin
         ramload = 32'hA000_0000 + 32'(c);
         #2;
         check_val("alt_dhit", dhit, (c == 3 || c == 11));
         check_val("alt_ihit", ihit, (c == 7 || c == 15));
         if ((c >= 1 && c <= 3) || (c >= 9 && c <= 11))
            check_val("alt_daddr", ramaddr, 32'h200);
         if ((c >= 5 && c <= 7) || (c >= 13 && c <= 15))
            check_val("alt_iaddr", ramaddr, 32'h100);
         if (c == 11) check_val("alt_dload", dload, 32'hA000_000B);
         if (c == 15) check_val("alt_iload", iload, 32'hA000_000F);
         cyc();
      end
      iREN = 1'b0; dREN = 1'b0;

      // fetch abort, then a normal data read
      do_reset();
      iREN = 1'b1; iaddr = 32'h44; ramload = 32'h7777_0000;
      for (int c = 0; c <= 7; c++) begin
         if (c == 2) iREN = 1'b0;
         if (c == 3) begin
            dREN = 1'b1; daddr = 32'h88; ramload = 32'h3333_4444;
         end
         if (c == 7) dREN = 1'b0;
         #2;
         check_val("ab_ihit",   ihit,   0);
         check_val("ab_dhit",   dhit,   (c == 6));
         check_val("ab_ramren", ramREN, (c >= 1 && c <= 2) || (c >= 4 && c <= 6));
         if (c >= 4 && c <= 6) check_val("ab_ramaddr", ramaddr, 32'h88);
         if (c == 6) check_val("ab_dload", dload, 32'h3333_4444);
         cyc();
      end

      // reset in the middle of a data write
      do_reset();
      dWEN = 1'b1; daddr = 32'h90; dstore = 32'hCAFE_F00D;
      for (int c = 0; c <= 6; c++) begin
         if (c == 2) RST = 1'b1;
         if (c == 3) begin
            RST = 1'b0; dWEN = 1'b0;
         end
         #2;
         if (c == 1) check_val("rm_ramwen_pre", ramWEN, 1);
         if (c >= 3) begin
            check_val("rm_dhit",     dhit,     0);
            check_val("rm_ramwen",   ramWEN,   0);
            check_val("rm_ramren",   ramREN,   0);
            check_val("rm_ramaddr",  ramaddr,  0);
            check_val("rm_ramstore", ramstore, 0);
            check_val("rm_dload",    dload,    0);
         end
         cyc();
      end

      // read and write together: write wins
      do_reset();
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'hA0; dstore = 32'h55AA_55AA;
      for (int c = 0; c <= 4; c++) begin
         if (c == 4) begin
            dREN = 1'b0; dWEN = 1'b0;
         end
         #2;
         check_val("rw_ramwen", ramWEN, (c >= 1 && c <= 3));
         check_val("rw_ramren", ramREN, 0);
         check_val("rw_dhit",   dhit,   (c == 3));
         if (c == 2) check_val("rw_ramstore", ramstore, 32'h55AA_55AA);
         cyc();
      end

      // LAT=0: hit in the first access cycle
      do_reset();
      iREN = 1'b1; iaddr = 32'h60; ramload = 32'h0000_1234;
      for (int c = 0; c <= 3; c++) begin
         if (c == 2) iREN = 1'b0;
         #2;
         check_val("l0_ihit",   ihit0,   (c == 1));
         check_val("l0_dhit",   dhit0,   0);
         check_val("l0_ramren", ramREN0, (c == 1));
         check_val("l0_ramwen", ramWEN0, 0);
         if (c == 1) begin
            check_val("l0_iload",   iload0,   32'h0000_1234);
            check_val("l0_ramaddr", ramaddr0, 32'h60);
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Single-ported memory arbiter between the instruction-fetch and data-access request ports and one fixed-latency RAM.
- It is the responder that generates ihit and dhit. The hazard unit consumes those to drive stage write enables and flushes.
- It serialises requests, holds the RAM port stable for a fixed number of wait cycles, and returns one-cycle hit strobes with read data.
- Arbitration gives data priority but alternates when both ports are pending back-to-back, so fetch is never starved.

Parameters:
- LAT, 2, wait cycles per RAM access (range 0..15); the hit occurs on access cycle LAT.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  AW  instruction address.
- ihit  out  1  one-cycle strobe: iload is valid this cycle.
- iload  out  DW  instruction read data.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  AW  data address.
- dstore  in  DW  data write value.
- dhit  out  1  one-cycle strobe: data access is complete; dload is valid for reads.
- dload  out  DW  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data; valid on access cycle LAT.

Behaviour:
- States: IDLE, IACC, DACC. Internal: 4-bit cnt, 1-bit last_d (1 = last completed grant was data), latched addr/data/op.
- Reset: state=IDLE, cnt=0, last_d=0.
  - All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore.
  - Reset is honoured in any state and aborts any access in flight with no hit.
- IDLE grant rules:
  - dreq = dREN|dWEN.
  - dreq & iREN & last_d → IACC.
  - Otherwise dreq → DACC.
  - Otherwise iREN → IACC.
  - Otherwise stay in IDLE.
  - On grant: latch the address; for DACC also latch dstore and op. Set cnt=0.
- Op encoding: dWEN=1 means write, whatever dREN is (write wins when both are set).
- RAM drive in IACC/DACC:
  - ramaddr = latched address.
  - IACC: ramREN=1, ramWEN=0.
  - DACC read: ramREN=1, ramWEN=0.
  - DACC write: ramWEN=1, ramREN=0, ramstore = latched dstore.
  - In IDLE, ramREN=ramWEN=0 and ramaddr/ramstore hold their last values.
- Access cycles: cnt increments every ACC cycle while cnt<LAT.
- Completion (cnt==LAT while the requester still asserts its request):
  - Assert ihit (IACC) or dhit (DACC) combinationally for exactly that cycle.
  - iload/dload = ramload combinationally that cycle, and registered to hold afterwards.
  - last_d <= (state==DACC); next state = IDLE.
- Latency: request first seen in IDLE at cycle t, hit at cycle t+1+LAT. Minimum gap between consecutive hits is LAT+2 cycles.
- Abort: if the granted requester drops its request before completion (iREN=0 in IACC; dREN=dWEN=0 in DACC):
  - Return to IDLE next cycle with no hit.
  - cnt resets and last_d is unchanged.
- Mid-access changes: iaddr/daddr/dstore changes after grant are ignored; the latched values are used.
- Hit exclusivity: ihit and dhit are never both 1. A hit is never asserted in IDLE.
- LAT=0: the hit occurs in the first ACC cycle.

Test Plan:
- Reset then iREN=1, iaddr=0x40, LAT=2, ramload=0xDEAD0001 → ramREN=1 and ramaddr=0x40 in cycles 1-3; ihit=1 only in cycle 3 with iload=0xDEAD0001; IDLE in cycle 4.
- dWEN=1, daddr=0x80, dstore=0x12345678 → ramWEN=1, ramstore=0x12345678 for 3 cycles; dhit at cycle 3; ihit stays 0.
- iREN and dREN both held continuously from reset → grant order D, I, D, I; hits at cycles 3, 7, 11, 15, alternating dhit/ihit.
- iREN granted, then deasserted at cycle 2 → no ihit; IDLE at cycle 3. A new dREN then completes normally with dhit at +3.
- RST=1 pulsed at cycle 2 of a DACC write → cycle 3: all outputs 0, state IDLE, no dhit ever from that access.
- dREN=dWEN=1 simultaneously → write performed (ramWEN=1, ramREN=0). Separately with LAT=0: iREN → ihit in cycle 1.
